vent_humidity_ctrl: RTL and testbench

Measurement scheduler and ventilation controller for the climate path. Periodically triggers the single-wire humidity reader, supervises each transaction (timeout, checksum, retry), latches validated humidity/temperature for the SPI status map, and configures the duty of the exhaust-vent PWM channel with hysteresis or host override. Sits between the humidity reader, the SPI register file and the PWM block, all on `clk50M`.

---
 rtl/vent_humidity_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vent_humidity_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vent_humidity_ctrl.sv
// Humidity measurement scheduler with timeout/checksum/retry supervision and
// exhaust-vent duty selection (auto hysteresis, forced off, host duty).
module vent_humidity_ctrl #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned STARTUP_MS = 1000,
   parameter int unsigned POLL_MS    = 5000,
   parameter int unsigned TIMEOUT_MS = 100,
   parameter int unsigned RETRY_MS   = 50,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned AUTO_DUTY  = 200,
   parameter int unsigned FAULT_DUTY = 128
) (
   input  logic        clk50M,
   input  logic        rst_n,
   output logic        meas_start,
   input  logic        meas_done,
   input  logic [39:0] meas_frame,
   input  logic [1:0]  host_mode,
   input  logic [7:0]  host_duty,
   input  logic [7:0]  rh_on,
   input  logic [7:0]  rh_off,
   output logic [7:0]  vent_duty,
   output logic [7:0]  rh_out,
   output logic [7:0]  t_out,
   output logic        data_valid,
   output logic        sensor_fault,
   output logic [7:0]  err_cnt
);

   typedef enum logic [2:0] {
      StStartup, StIdle, StStart, StWait, StCheck, StBackoff
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] presc_q, presc_d, ms_q, ms_d;
   logic [31:0] poll_presc_q, poll_presc_d, poll_ms_q, poll_ms_d;
   logic [31:0] retry_q, retry_d;
   logic [39:0] frame_q, frame_d;
   logic [7:0]  rh_q, rh_d, t_q, t_d, err_q, err_d, duty_q, duty_d;
   logic        valid_q, valid_d, fault_q, fault_d, fan_q, fan_d;
   logic        tick_last, poll_done, fail;
   logic [7:0]  csum;

   assign tick_last = (presc_q == TICK_DIV - 1);
   // Poll period counts from the first attempt of a poll; saturates once elapsed.
   assign poll_done = (poll_ms_q >= POLL_MS) ||
                      ((poll_ms_q == POLL_MS - 1) && (poll_presc_q == TICK_DIV - 1));
   assign csum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      retry_d = retry_q;
      rh_d    = rh_q;
      t_d     = t_q;
      valid_d = valid_q;
      fault_d = fault_q;
      err_d   = err_q;
      fail    = 1'b0;

      case (state_q)
         StStartup: if (tick_last && ms_q == STARTUP_MS - 1) state_d = StStart;
         StIdle:    if (poll_done) state_d = StStart;
         StStart:   state_d = StWait;
         StWait: begin
            // A frame arriving on the expiry cycle takes priority over the timeout.
            if (meas_done) begin
               frame_d = meas_frame;
               state_d = StCheck;
            end else if (tick_last && ms_q == TIMEOUT_MS - 1) begin
               fail = 1'b1;
            end
         end
         StCheck: begin
            if (csum == frame_q[7:0]) begin
               rh_d    = frame_q[39:32];
               t_d     = frame_q[23:16];
               valid_d = 1'b1;
               fault_d = 1'b0;
               retry_d = '0;
               state_d = StIdle;
            end else begin
               fail = 1'b1;
            end
         end
         StBackoff: if (tick_last && ms_q == RETRY_MS - 1) state_d = StStart;
         default:   state_d = StStartup;
      endcase

      if (fail) begin
         err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
         if (retry_q + 32'd1 < MAX_RETRY) begin
            retry_d = retry_q + 32'd1;
            state_d = StBackoff;
         end else begin
            fault_d = 1'b1;
            retry_d = '0;
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      presc_d = presc_q + 32'd1;
      ms_d    = ms_q;
      if (state_d != state_q) begin
         presc_d = '0;
         ms_d    = '0;
      end else if (tick_last) begin
         presc_d = '0;
         ms_d    = ms_q + 32'd1;
      end

      poll_presc_d = poll_presc_q;
      poll_ms_d    = poll_ms_q;
      if (state_d == StStart && state_q != StStart && state_q != StBackoff) begin
         poll_presc_d = '0;
         poll_ms_d    = '0;
      end else if (poll_ms_q < POLL_MS) begin
         if (poll_presc_q == TICK_DIV - 1) begin
            poll_presc_d = '0;
            poll_ms_d    = poll_ms_q + 32'd1;
         end else begin
            poll_presc_d = poll_presc_q + 32'd1;
         end
      end
   end

   // Fan latch; overlapping thresholds degrade to a plain comparator.
   always_comb begin
      fan_d = fan_q;
      if (valid_q) begin
         if (rh_on <= rh_off) begin
            fan_d = (rh_q >= rh_on);
         end else if (rh_q >= rh_on) begin
            fan_d = 1'b1;
         end else if (rh_q <= rh_off) begin
            fan_d = 1'b0;
         end
      end
   end

   always_comb begin
      duty_d = '0;
      case (host_mode)
         2'b01:   duty_d = '0;
         2'b10:   duty_d = host_duty;
         default: begin
            if (fault_q)    duty_d = FAULT_DUTY[7:0];
            else if (fan_d) duty_d = AUTO_DUTY[7:0];
            else            duty_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StStartup;
         presc_q      <= '0;
         ms_q         <= '0;
         poll_presc_q <= '0;
         poll_ms_q    <= '0;
         retry_q      <= '0;
         frame_q      <= '0;
         rh_q         <= '0;
         t_q          <= '0;
         valid_q      <= 1'b0;
         fault_q      <= 1'b0;
         err_q        <= '0;
         fan_q        <= 1'b0;
         duty_q       <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         ms_q         <= ms_d;
         poll_presc_q <= poll_presc_d;
         poll_ms_q    <= poll_ms_d;
         retry_q      <= retry_d;
         frame_q      <= frame_d;
         rh_q         <= rh_d;
         t_q          <= t_d;
         valid_q      <= valid_d;
         fault_q      <= fault_d;
         err_q        <= err_d;
         fan_q        <= fan_d;
         duty_q       <= duty_d;
      end
   end

   assign meas_start   = (state_q == StStart);
   assign vent_duty    = duty_q;
   assign rh_out       = rh_q;
   assign t_out        = t_q;
   assign data_valid   = valid_q;
   assign sensor_fault = fault_q;
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_vent_humidity_ctrl.sv
// Self-checking bench for vent_humidity_ctrl: scoreboard of expected outputs
// per frame, plus scheduling-gap and host-override checks.
module tb_vent_humidity_ctrl;

   logic        clk50M = 1'b0;
   logic        rst_n;
   logic        meas_start;
   logic        meas_done;
   logic [39:0] meas_frame;
   logic [1:0]  host_mode;
   logic [7:0]  host_duty, rh_on, rh_off;
   logic [7:0]  vent_duty, rh_out, t_out, err_cnt;
   logic        data_valid, sensor_fault;

   vent_humidity_ctrl #(
      .TICK_DIV(4), .STARTUP_MS(2), .POLL_MS(10), .TIMEOUT_MS(3), .RETRY_MS(2),
      .MAX_RETRY(3), .AUTO_DUTY(200), .FAULT_DUTY(128)
   ) dut (
      .clk50M(clk50M), .rst_n(rst_n), .meas_start(meas_start), .meas_done(meas_done),
      .meas_frame(meas_frame), .host_mode(host_mode), .host_duty(host_duty),
      .rh_on(rh_on), .rh_off(rh_off), .vent_duty(vent_duty), .rh_out(rh_out),
      .t_out(t_out), .data_valid(data_valid), .sensor_fault(sensor_fault),
      .err_cnt(err_cnt)
   );

   always #5 clk50M = ~clk50M;

   int cyc = 0;
   always @(posedge clk50M) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] rh;
      logic [7:0] t;
      logic       valid;
      logic       fault;
      logic [7:0] err;
      logic [7:0] duty;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   logic [7:0] m_rh, m_t, m_err;
   logic       m_valid, m_fault, m_fan;
   int         m_retry;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk50M);
      #1;
   endtask

   task automatic wait_start(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk50M);
         #1;
         if (meas_start) begin
            at = cyc;
            return;
         end
      end
   endtask

   function automatic logic [39:0] mk_frame(input logic [7:0] rh, input logic [7:0] rd,
                                            input logic [7:0] t, input logic [7:0] td,
                                            input logic bad);
      logic [7:0] cs;
      cs = rh + rd + t + td;
      if (bad) cs = cs + 8'd1;
      return {rh, rd, t, td, cs};
   endfunction

   task automatic model_reset();
      m_rh = 0; m_t = 0; m_err = 0; m_valid = 0; m_fault = 0; m_fan = 0; m_retry = 0;
      sb_q.delete();
   endtask

   task automatic model_fan_eval();
      if (m_valid) begin
         if (rh_on <= rh_off)    m_fan = (m_rh >= rh_on);
         else if (m_rh >= rh_on)  m_fan = 1'b1;
         else if (m_rh <= rh_off) m_fan = 1'b0;
      end
   endtask

   function automatic logic [7:0] model_duty();
      if (host_mode == 2'b01) return 8'd0;
      if (host_mode == 2'b10) return host_duty;
      return m_fault ? 8'd128 : (m_fan ? 8'd200 : 8'd0);
   endfunction

   task automatic model_fail();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      m_retry++;
      if (m_retry >= 3) begin
         m_fault = 1'b1;
         m_retry = 0;
      end
   endtask

   // Drive one meas_done pulse; push what the DUT should show once it settles.
   task automatic send_frame(input logic [39:0] f, input logic accepted);
      exp_t e;
      logic [7:0] s;
      if (accepted) begin
         s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
         if (s == f[7:0]) begin
            m_rh = f[39:32]; m_t = f[23:16]; m_valid = 1'b1; m_fault = 1'b0; m_retry = 0;
         end else begin
            model_fail();
         end
         model_fan_eval();
      end
      e.rh = m_rh; e.t = m_t; e.valid = m_valid; e.fault = m_fault; e.err = m_err;
      e.duty = model_duty();
      sb_q.push_back(e);
      meas_frame = f;
      meas_done  = 1'b1;
      tick(1);
      meas_done  = 1'b0;
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      tick(1);
      if (sb_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check_eq({tag, "_rh"}, rh_out, e.rh);
      check_eq({tag, "_t"}, t_out, e.t);
      check_eq({tag, "_valid"}, data_valid, e.valid);
      check_eq({tag, "_fault"}, sensor_fault, e.fault);
      check_eq({tag, "_err"}, err_cnt, e.err);
      tick(1);
      check_eq({tag, "_duty"}, vent_duty, e.duty);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_start"}, meas_start, 0);
      check_eq({tag, "_duty"}, vent_duty, 0);
      check_eq({tag, "_rh"}, rh_out, 0);
      check_eq({tag, "_t"}, t_out, 0);
      check_eq({tag, "_valid"}, data_valid, 0);
      check_eq({tag, "_fault"}, sensor_fault, 0);
      check_eq({tag, "_err"}, err_cnt, 0);
   endtask

   // Startup pulse, timeout of the first attempt, then a retry 21 cycles later.
   task automatic startup_sequence(input int c0, input string tag, output int t_first,
                                   output int t_retry);
      wait_start(40, t_first);
      check_eq({tag, "_first_start"}, t_first - c0, 8);
      tick(1);
      check_eq({tag, "_start_width"}, meas_start, 0);
      wait_start(40, t_retry);
      model_fail();
      check_eq({tag, "_retry_gap"}, t_retry - t_first, 21);
      check_eq({tag, "_err_timeout"}, err_cnt, m_err);
   endtask

   initial begin
      int c0, t1, t2, tn, tp;
      rst_n = 1'b0; meas_done = 1'b0; meas_frame = '0;
      host_mode = 2'b00; host_duty = 8'h00; rh_on = 8'd55; rh_off = 8'd45;
      model_reset();
      #1;
      check_all_zero("reset");
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;

      startup_sequence(c0, "boot", t1, t2);
      tick(1);
      send_frame(40'h3C_00_19_00_55, 1'b1);
      check_result("first_good");

      wait_start(60, tn);
      check_eq("poll_period", tn - t1, 40);
      tick(1);
      send_frame(mk_frame(8'd50, 8'd0, 8'd25, 8'd0, 1'b0), 1'b1);
      check_result("hyst_50_hold_on");

      wait_start(60, tp);
      check_eq("poll_period2", tp - tn, 40);
      tick(1);
      send_frame(mk_frame(8'd44, 8'd5, 8'd24, 8'd3, 1'b0), 1'b1);
      check_result("hyst_44_off");

      wait_start(60, tn);
      tick(1);
      send_frame(mk_frame(8'd50, 8'd0, 8'd26, 8'd0, 1'b0), 1'b1);
      check_result("hyst_50_hold_off");

      // Three checksum failures within one poll.
      wait_start(60, tp);
      t1 = tp;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            wait_start(30, tn);
            check_eq($sformatf("bad_retry_gap%0d", i), tn - tp, 11);
            tp = tn;
         end
         tick(1);
         send_frame(mk_frame(8'd80, 8'd1, 8'd30, 8'd2, 1'b1), 1'b1);
         check_result($sformatf("bad_csum%0d", i));
      end
      wait_start(60, tn);
      check_eq("poll_after_fault", tn - t1, 40);
      tick(1);
      // Checksum sum wraps past 255.
      send_frame(mk_frame(8'd90, 8'd200, 8'd30, 8'd10, 1'b0), 1'b1);
      check_result("recover_wrap");

      // Frame arrives exactly on the timeout expiry cycle.
      wait_start(60, tn);
      tick(12);
      send_frame(mk_frame(8'd40, 8'd0, 8'd20, 8'd0, 1'b0), 1'b1);
      check_result("expiry_accept");

      tick(2);
      send_frame(mk_frame(8'd70, 8'd0, 8'd21, 8'd0, 1'b0), 1'b0);
      check_result("idle_ignored");

      host_mode = 2'b10; host_duty = 8'h7F;
      tick(1);
      check_eq("host_duty", vent_duty, 8'h7F);
      rh_on = 8'd30; host_mode = 2'b01;
      tick(1);
      model_fan_eval();
      check_eq("forced_off", vent_duty, 0);
      host_mode = 2'b11;
      tick(1);
      check_eq("mode11_auto", vent_duty, model_duty());
      rh_on = 8'd55;
      tick(1);
      model_fan_eval();
      check_eq("thr_clear", vent_duty, model_duty());
      rh_on = 8'd40; rh_off = 8'd50;
      tick(1);
      model_fan_eval();
      check_eq("overlap_eq", vent_duty, model_duty());
      rh_on = 8'd41;
      tick(1);
      model_fan_eval();
      check_eq("overlap_below", vent_duty, model_duty());
      rh_on = 8'd55; rh_off = 8'd45; host_mode = 2'b00;
      tick(1);
      model_fan_eval();
      check_eq("auto_restore", vent_duty, model_duty());

      // Reset mid-WAIT, then a stale meas_done during STARTUP.
      wait_start(60, tn);
      check_eq("pre_reset_start_seen", tn > 0, 1);
      tick(2);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      tick(2);
      rst_n = 1'b1;
      c0 = cyc;
      model_reset();
      send_frame(40'h3C_00_19_00_55, 1'b0);
      check_result("late_done");
      startup_sequence(c0, "reboot", t1, t2);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
